// File: rtl/instr_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder:
// field classes, opcodes, funct7 values, illegal-reason codes and FSM states.
package instr_enc_pkg;

    typedef enum logic [3:0] {
        CLS_LOAD   = 4'd0,
        CLS_STORE  = 4'd1,
        CLS_LUI    = 4'd2,
        CLS_AUIPC  = 4'd3,
        CLS_OP     = 4'd4,
        CLS_OPIMM  = 4'd5,
        CLS_BRANCH = 4'd6,
        CLS_JAL    = 4'd7,
        CLS_JALR   = 4'd8,
        CLS_MULDIV = 4'd9
    } instr_class_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        ILL_NONE      = 3'd0,
        ILL_CLASS     = 3'd1,
        ILL_IMM_RANGE = 3'd2,
        ILL_IMM_ALIGN = 3'd3,
        ILL_FUNCT3    = 3'd4
    } ill_reason_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FULL   = 2'd2,
        ST_ERR    = 2'd3
    } enc_state_e;

    // funct7 for OP and the upper shift-immediate bits: alt only lands in bit 30
    function automatic logic [6:0] alt_funct7(input logic alt);
        return {1'b0, alt, 5'b00000};
    endfunction

endpackage

// File: rtl/instr_enc_pack.sv
// Combinational field-to-word packer with legality check.
// Macro INSTR_ENC_RVM_EN makes class 9 (MULDIV) a legal class.
module instr_pack
    import instr_enc_pkg::*;
(
    input  logic [3:0]  in_class,
    input  logic [2:0]  in_funct3,
    input  logic        in_alt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic [31:0] word,
    output logic        legal
);

    ill_reason_e reason;
    logic        imm_i_ok;
    logic        imm_b_ok;
    logic        imm_j_ok;
    logic        shamt_ok;
    logic        imm_u_ok;
    logic        is_shift;

    // a value fits a signed N-bit field when all bits from N-1 upward agree
    assign imm_i_ok = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
    assign imm_b_ok = (in_imm[31:12] == '0) || (in_imm[31:12] == '1);
    assign imm_j_ok = (in_imm[31:20] == '0) || (in_imm[31:20] == '1);
    assign shamt_ok = (in_imm[31:5] == '0);
    assign imm_u_ok = (in_imm[11:0] == '0);
    assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

    // pack the word for the selected format and flag the first legality problem
    always_comb begin
        word   = '0;
        reason = ILL_NONE;
        case (in_class)
            CLS_LOAD: begin
                word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
                if (in_funct3 == 3'd3 || in_funct3 == 3'd6 || in_funct3 == 3'd7)
                    reason = ILL_FUNCT3;
                else if (!imm_i_ok)
                    reason = ILL_IMM_RANGE;
            end
            CLS_STORE: begin
                word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OPC_STORE};
                if (in_funct3 > 3'd2)
                    reason = ILL_FUNCT3;
                else if (!imm_i_ok)
                    reason = ILL_IMM_RANGE;
            end
            CLS_LUI: begin
                word = {in_imm[31:12], in_rd, OPC_LUI};
                if (!imm_u_ok)
                    reason = ILL_IMM_ALIGN;
            end
            CLS_AUIPC: begin
                word = {in_imm[31:12], in_rd, OPC_AUIPC};
                if (!imm_u_ok)
                    reason = ILL_IMM_ALIGN;
            end
            CLS_OP: begin
                word = {(is_shift || in_funct3 == 3'b000) && in_funct3 != 3'b001
                            ? alt_funct7(in_alt) : F7_ZERO,
                        in_rs2, in_rs1, in_funct3, in_rd, OPC_OP};
            end
            CLS_OPIMM: begin
                if (is_shift) begin
                    word = {alt_funct7(in_alt), in_imm[4:0], in_rs1, in_funct3, in_rd, OPC_OPIMM};
                    if (!shamt_ok)
                        reason = ILL_IMM_RANGE;
                end else begin
                    word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_OPIMM};
                    if (!imm_i_ok)
                        reason = ILL_IMM_RANGE;
                end
            end
            CLS_BRANCH: begin
                word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], OPC_BRANCH};
                if (in_funct3 == 3'd2 || in_funct3 == 3'd3)
                    reason = ILL_FUNCT3;
                else if (in_imm[0])
                    reason = ILL_IMM_ALIGN;
                else if (!imm_b_ok)
                    reason = ILL_IMM_RANGE;
            end
            CLS_JAL: begin
                word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
                if (in_imm[0])
                    reason = ILL_IMM_ALIGN;
                else if (!imm_j_ok)
                    reason = ILL_IMM_RANGE;
            end
            CLS_JALR: begin
                word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_JALR};
                if (in_funct3 != 3'd0)
                    reason = ILL_FUNCT3;
                else if (!imm_i_ok)
                    reason = ILL_IMM_RANGE;
            end
`ifdef INSTR_ENC_RVM_EN
            CLS_MULDIV: begin
                word = {F7_MULDIV, in_rs2, in_rs1, in_funct3, in_rd, OPC_OP};
            end
`endif
            default: begin
                reason = ILL_CLASS;
            end
        endcase
    end

    assign legal = (reason == ILL_NONE);

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: accepts decoded field sets, packs them and writes
// legal words sequentially into instruction memory via a registered port.
// Optional macro INSTR_ENC_RVM_EN (handled in instr_pack) enables MULDIV.
//
// state  | meaning
// IDLE   | waiting for the first start
// STREAM | accepting field sets, writing words
// FULL   | DEPTH words written and drained; waiting for start
// ERR    | illegal field seen with HALT_ON_ERR=1; waiting for start
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 256,
    parameter int HALT_ON_ERR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_class,
    input  logic [2:0]        in_funct3,
    input  logic              in_alt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err,
    output logic [7:0]        err_cnt
);

    localparam int              CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    enc_state_e       state;
    enc_state_e       next_state;
    logic [CNT_W-1:0] count;
    logic [31:0]      word;
    logic             word_legal;
    logic             accept;
    logic             drain;

    instr_pack u_pack (
        .in_class  (in_class),
        .in_funct3 (in_funct3),
        .in_alt    (in_alt),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .word      (word),
        .legal     (word_legal)
    );

    assign in_ready = (state == ST_STREAM) && (count < DEPTH_C) && (!mem_we || mem_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = mem_we && mem_ready;
    assign done     = (state == ST_FULL);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // next-state logic; start restarts the stream from any state
    always_comb begin
        next_state = state;
        if (start) begin
            next_state = ST_STREAM;
        end else begin
            case (state)
                ST_STREAM: begin
                    if (accept && !word_legal && (HALT_ON_ERR != 0))
                        next_state = ST_ERR;
                    else if (count == DEPTH_C && !mem_we)
                        next_state = ST_FULL;
                end
                default: next_state = state;
            endcase
        end
    end

    // output register, address/word counter and error bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else if (start) begin
            mem_we   <= 1'b0;
            mem_addr <= base_addr & ~ADDR_W'(3);
            count    <= '0;
            err      <= 1'b0;
            err_cnt  <= '0;
        end else begin
            if (drain) begin
                mem_we   <= 1'b0;
                mem_addr <= mem_addr + ADDR_W'(4);
            end
            if (accept) begin
                if (word_legal) begin
                    mem_we    <= 1'b1;
                    mem_wdata <= word;
                    count     <= count + CNT_W'(1);
                end else begin
                    err <= 1'b1;
                    if (err_cnt != 8'hFF)
                        err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: two instances (HALT_ON_ERR 0 and 1),
// both DEPTH=4, sharing stimulus.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic        in_valid;
    logic [3:0]  in_class;
    logic [2:0]  in_funct3;
    logic        in_alt;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        mem_ready;

    logic        in_ready, mem_we, done, err;
    logic [31:0] mem_addr, mem_wdata;
    logic [7:0]  err_cnt;

    logic        h_in_ready, h_mem_we, h_done, h_err;
    logic [31:0] h_mem_addr, h_mem_wdata;
    logic [7:0]  h_err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(32), .DEPTH(4), .HALT_ON_ERR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
        .in_funct3(in_funct3), .in_alt(in_alt), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .mem_we(mem_we), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done), .err(err),
        .err_cnt(err_cnt)
    );

    instr_encoder #(.ADDR_W(32), .DEPTH(4), .HALT_ON_ERR(1)) dut_h (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(h_in_ready), .in_class(in_class),
        .in_funct3(in_funct3), .in_alt(in_alt), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .mem_we(h_mem_we), .mem_ready(mem_ready),
        .mem_addr(h_mem_addr), .mem_wdata(h_mem_wdata), .done(h_done), .err(h_err),
        .err_cnt(h_err_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic [2:0] f3, input logic alt,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
        in_class  = c;
        in_funct3 = f3;
        in_alt    = alt;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        in_valid  = 1'b1;
    endtask

    task automatic do_start(input logic [31:0] base);
        in_valid  = 1'b0;
        base_addr = base;
        start     = 1'b1;
        step();
        start = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  c;
        logic [2:0]  f3;
        logic [31:0] imm;
    } ill_vec_t;

    ill_vec_t ev[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ev[0]  = '{4'd2, 3'd0, 32'h1234_5001};   // LUI low bits set
        ev[1]  = '{4'd6, 3'd0, 32'd7};           // branch odd
        ev[2]  = '{4'd6, 3'd0, 32'd4096};        // branch out of range
        ev[3]  = '{4'd7, 3'd0, 32'h0010_0000};   // jal +1 MiB
        ev[4]  = '{4'd1, 3'd3, 32'd0};           // store funct3 3
        ev[5]  = '{4'd0, 3'd6, 32'd0};           // load funct3 6
        ev[6]  = '{4'd8, 3'd1, 32'd0};           // jalr funct3 1
        ev[7]  = '{4'd5, 3'd1, 32'd32};          // slli shamt 32
        ev[8]  = '{4'd5, 3'd0, 32'hFFFF_F7FF};   // addi -2049
        ev[9]  = '{4'd9, 3'd0, 32'd0};           // MULDIV, disabled build
        ev[10] = '{4'd15, 3'd0, 32'd0};          // undefined class

        rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        in_class = '0; in_funct3 = '0; in_alt = 1'b0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; mem_ready = 1'b1;
        step();
        step();
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        check_eq("rst_flags", {29'd0, done, err, 1'b0}, 32'd0);
        check_eq("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        rst = 1'b0;
        step();
        check_eq("idle_in_ready", {31'd0, in_ready}, 32'd0);

        // addi x1,x0,5
        do_start(32'h100);
        check_eq("stream_in_ready", {31'd0, in_ready}, 32'd1);
        drive(4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        step();
        in_valid = 1'b0;
        check_eq("addi_we", {31'd0, mem_we}, 32'd1);
        check_eq("addi_addr", mem_addr, 32'h100);
        check_eq("addi_data", mem_wdata, 32'h0050_0093);
        step();
        check_eq("addi_drained", {31'd0, mem_we}, 32'd0);
        check_eq("addi_addr_adv", mem_addr, 32'h104);

        // sub x3,x1,x2 ; sw x2,12(x1) back-to-back
        do_start(32'h100);
        drive(4'd4, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
        step();
        check_eq("sub_data", mem_wdata, 32'h4020_81B3);
        check_eq("sub_addr", mem_addr, 32'h100);
        drive(4'd1, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd12);
        step();
        in_valid = 1'b0;
        check_eq("sw_data", mem_wdata, 32'h0020_A623);
        check_eq("sw_addr", mem_addr, 32'h104);
        check_eq("sw_we", {31'd0, mem_we}, 32'd1);
        step();

        // beq x1,x2,+8 ; jal x1,+2048 ; lui x5,0x12345000
        do_start(32'h203);
        drive(4'd6, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
        step();
        check_eq("beq_data", mem_wdata, 32'h0020_8463);
        check_eq("beq_addr", mem_addr, 32'h200);
        drive(4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
        step();
        check_eq("jal_data", mem_wdata, 32'h0010_00EF);
        drive(4'd2, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        step();
        in_valid = 1'b0;
        check_eq("lui_data", mem_wdata, 32'h1234_52B7);
        check_eq("lui_addr", mem_addr, 32'h208);
        step();

        // mem_ready stall for 3 cycles
        do_start(32'h300);
        mem_ready = 1'b0;
        drive(4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        step();
        drive(4'd4, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check_eq("stall_we", {31'd0, mem_we}, 32'd1);
            check_eq("stall_addr", mem_addr, 32'h300);
            check_eq("stall_data", mem_wdata, 32'h0050_0093);
            step();
        end
        mem_ready = 1'b1;
        #1;
        check_eq("stall_release_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check_eq("stall_next_data", mem_wdata, 32'h4020_81B3);
        check_eq("stall_next_addr", mem_addr, 32'h304);
        step();

        // boundary immediates, address wrap and DEPTH=4 limit
        do_start(32'hFFFF_FFF8);
        drive(4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800);
        step();
        check_eq("addi_min_data", mem_wdata, 32'h8000_0093);
        check_eq("addi_min_addr", mem_addr, 32'hFFFF_FFF8);
        drive(4'd6, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_F000);
        step();
        check_eq("beq_min_data", mem_wdata, 32'h8000_0063);
        drive(4'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFF0_0000);
        step();
        check_eq("jal_min_data", mem_wdata, 32'h8000_006F);
        check_eq("wrap_addr", mem_addr, 32'h0);
        drive(4'd5, 3'd5, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3);
        step();
        check_eq("srai_data", mem_wdata, 32'h4030_D093);
        check_eq("depth_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done) break;
            step();
        end
        check_eq("full_done", {31'd0, done}, 32'd1);
        check_eq("full_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("full_addr", mem_addr, 32'h8);

        // illegal immediate: drop-and-continue vs halt
        do_start(32'h400);
        drive(4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
        step();
        in_valid = 1'b0;
        check_eq("ill_no_write", {31'd0, mem_we}, 32'd0);
        check_eq("ill_err", {31'd0, err}, 32'd1);
        check_eq("ill_err_cnt", {24'd0, err_cnt}, 32'd1);
        check_eq("ill_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("halt_in_ready", {31'd0, h_in_ready}, 32'd0);
        check_eq("halt_err", {31'd0, h_err}, 32'd1);
        drive(4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        step();
        check_eq("after_ill_addr", mem_addr, 32'h400);
        check_eq("after_ill_data", mem_wdata, 32'h0050_0093);
        check_eq("halt_no_write", {31'd0, h_mem_we}, 32'd0);
        for (int i = 0; i < 11; i++) begin
            drive(ev[i].c, ev[i].f3, 1'b0, 5'd1, 5'd2, 5'd3, ev[i].imm);
            step();
            in_valid = 1'b0;
            check_eq($sformatf("ill_vec%0d_cnt", i), {24'd0, err_cnt}, 32'(i + 2));
            check_eq($sformatf("ill_vec%0d_we", i), {31'd0, mem_we}, 32'd0);
        end
        check_eq("halt_still_blocked", {31'd0, h_in_ready}, 32'd0);
        check_eq("halt_not_done", {31'd0, h_done}, 32'd0);

        // asynchronous reset during a stalled write
        mem_ready = 1'b0;
        drive(4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        step();
        in_valid = 1'b0;
        check_eq("pre_rst_we", {31'd0, mem_we}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_we", {31'd0, mem_we}, 32'd0);
        check_eq("arst_addr", mem_addr, 32'd0);
        check_eq("arst_data", mem_wdata, 32'd0);
        check_eq("arst_err", {30'd0, err, h_err}, 32'd0);
        check_eq("arst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check_eq("arst_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        rst = 1'b0;
        mem_ready = 1'b1;
        step();
        do_start(32'h500);
        check_eq("restart_in_ready", {30'd0, in_ready, h_in_ready}, 32'd3);
        check_eq("restart_addr", mem_addr, 32'h500);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming RV32I instruction encoder; the inverse of the core's instruction decode.
- Accepts decoded fields (class, funct3, alt bit, rd/rs1/rs2, full 32-bit immediate) over a valid/ready handshake and packs the 32-bit instruction word.
- Range-checks each immediate and writes legal words sequentially into instruction memory through a registered write port.
- Used by the boot/self-test loader to fill imem before the single-cycle core is released.

Parameters:
- ADDR_W, 32, width of the instruction-memory byte address.
- DEPTH, 256, max words written per stream before the block stops accepting.
- HALT_ON_ERR, 1: 1 = stop streaming on an illegal field; 0 = drop the word and continue.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  pulse; loads base_addr and begins a stream
- base_addr  in  ADDR_W  first write address; bits [1:0] ignored, treated as 0
- in_valid  in  1  field set valid
- in_ready  out  1  block can accept a field set
- in_class  in  4  0 LOAD, 1 STORE, 2 LUI, 3 AUIPC, 4 OP, 5 OPIMM, 6 BRANCH, 7 JAL, 8 JALR; others illegal
- in_funct3  in  3  funct3
- in_alt  in  1  instr[30] select (SUB/SRA/SRAI)
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  signed immediate or byte offset
- mem_we  out  1  write strobe (valid)
- mem_ready  in  1  memory accepts the write this cycle
- mem_addr  out  ADDR_W  word-aligned write address
- mem_wdata  out  32  encoded instruction
- done  out  1  high while in FULL
- err  out  1  sticky; cleared by start
- err_cnt  out  8  count of dropped words; saturates at 255; cleared by start

Behaviour:
- Reset is asynchronous, active-high, all registers.
  - Reset values: state IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, done 0, err 0, err_cnt 0, word counter 0.
- States:
  - IDLE: start -> STREAM.
  - STREAM: accepted word count reaches DEPTH and output register empty -> FULL. Illegal field with HALT_ON_ERR=1 -> ERR.
  - FULL and ERR: start -> STREAM. Otherwise hold.
  - start in any state loads base_addr, clears counter/err/err_cnt and discards an undelivered output word.
- Handshake:
  - in_ready = STREAM && count<DEPTH && (!mem_we || mem_ready).
  - A field set is accepted when in_valid && in_ready.
- Output register:
  - The word appears on mem_wdata with mem_we=1 the cycle after acceptance (latency 1).
  - mem_we, mem_addr and mem_wdata are held stable until mem_ready.
  - On mem_ready, mem_addr advances by 4, wrapping modulo 2^ADDR_W.
  - Back-to-back acceptance with mem_ready held high gives one word per cycle.
- Encoding uses standard RV32I formats: I/S/B/U/J immediate scatter and opcodes 0000011, 0100011, 0110111, 0010111, 0110011, 0010011, 1100011, 1101111, 1100111.
  - OP: funct7 = {1'b0, in_alt, 5'b0} only for funct3 000 and 101; otherwise 0.
  - OPIMM shifts: imm[11:5] = {1'b0, in_alt, 5'b0}, imm[4:0] = in_imm[4:0].
- Illegal conditions (word not written, not counted):
  - Undefined class.
  - I/S imm outside [-2048, 2047].
  - Shift imm outside [0, 31].
  - U imm with low 12 bits nonzero.
  - B imm odd or outside [-4096, 4094].
  - J imm odd or outside ±1 MiB.
  - LOAD funct3 in {3, 6, 7}; STORE funct3 > 2; BRANCH funct3 in {2, 3}; JALR funct3 != 0.
- An illegal word sets err and increments err_cnt (saturating at 255).
  - With HALT_ON_ERR=1, an already-pending output word still drains.
- Reset mid-write: mem_we drops immediately; the word is lost.

Optional Feature:
- INSTR_ENC_RVM_EN defined: class 9 MULDIV is legal and encodes opcode 0110011 with funct7 0000001 and any funct3.
- Undefined: class 9 is illegal, handled like any other illegal class.

Decomposition:
- Package instr_enc_pkg holds:
  - class enum and opcode constants;
  - funct7 constants;
  - illegal-reason codes.
- One natural sub-module: instr_pack, a combinational field-to-word packer plus legality check.
  - The top holds the FSM, counters and output register.

Test Plan:
- start base 0x100; addi x1,x0,5 (OPIMM f3=0 imm 5) -> mem_we next cycle, addr 0x100, data 0x00500093.
- sub x3,x1,x2 then sw x2,12(x1) back-to-back, mem_ready=1 -> 0x402081B3 @0x100, 0x0020A623 @0x104.
- beq x1,x2,+8 / jal x1,+2048 / lui x5,0x12345000 -> 0x00208463, 0x001000EF, 0x123452B7.
- mem_ready low 3 cycles -> mem_we/addr/data stable, in_ready 0; word accepted on the 4th cycle.
- addi imm 2048, HALT_ON_ERR=0 -> no write, err=1, err_cnt=1, next legal word lands at unchanged address; with HALT_ON_ERR=1 -> state ERR, in_ready 0 until start.
- DEPTH=4: 4 words -> done=1, in_ready 0; assert rst during a stalled write -> all outputs reset values immediately.
